// File: rtl/mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_ctrl
// Function : HI/LO owner and sequencer for an external pipelined unsigned
//            multiplier. Optional MADD support via macro MULT_CTRL_MADD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mult_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  input  logic               flush,
  output logic               op_ready,
  output logic               rd_valid,
  output logic [WIDTH-1:0]   rd_data,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MFHI  = 3'd3;
  localparam logic [2:0] OP_MFLO  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int            CW   = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] LAT  = CW'(MUL_LAT);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = '0;

  logic [0:0]         state;
  logic [0:0]         state_nxt;
  logic [CW-1:0]      cnt;
  logic               sign;
  logic               accept;
  logic               is_madd;
  logic               signed_op;
  logic               launch;
  logic               done;
  logic [WIDTH-1:0]   abs_rs;
  logic [WIDTH-1:0]   abs_rt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] commit;

  assign accept    = op_valid & op_ready;
  assign signed_op = (op == OP_MULT) | is_madd;
  assign launch    = accept & (signed_op | (op == OP_MULTU));
  assign done      = (state == S_RUN) & (cnt == ONE) & ~flush;

  // Two's-complement negation; the most negative value maps onto itself, which is
  // exactly its magnitude when read as unsigned.
  assign abs_rs = rs_val[WIDTH-1] ? -rs_val : rs_val;
  assign abs_rt = rt_val[WIDTH-1] ? -rt_val : rt_val;
  assign prod   = sign ? -mul_p : mul_p;

`ifdef MULT_CTRL_MADD_EN
  localparam logic [2:0] OP_MADD = 3'd7;
  logic acc;

  assign is_madd = (op == OP_MADD);
  assign commit  = acc ? ({hi, lo} + prod) : prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               acc <= 1'b0;
    else if (flush | done) acc <= 1'b0;
    else if (launch)       acc <= is_madd;
  end
`else
  assign is_madd = 1'b0;
  assign commit  = prod;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= ZERO;
    end else begin
      state <= state_nxt;
      if (flush)               cnt <= ZERO;
      else if (launch)         cnt <= LAT;
      else if (state == S_RUN) cnt <= cnt - ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (launch) state_nxt = S_RUN;
        S_RUN:   if (cnt == ONE) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    op_ready = (state == S_IDLE) & ~flush;
    rd_valid = 1'b0;
    rd_data  = '0;
    if (accept && op == OP_MFHI) begin
      rd_valid = 1'b1;
      rd_data  = hi;
    end else if (accept && op == OP_MFLO) begin
      rd_valid = 1'b1;
      rd_data  = lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      mul_a <= '0;
      mul_b <= '0;
      sign  <= 1'b0;
    end else begin
      if (launch) begin
        sign  <= signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
        mul_a <= signed_op ? abs_rs : rs_val;
        mul_b <= signed_op ? abs_rt : rt_val;
      end
      if (done) begin
        {hi, lo} <= commit;
      end else if (accept && op == OP_MTHI) begin
        hi <= rs_val;
      end else if (accept && op == OP_MTLO) begin
        lo <= rs_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_ctrl
// Function : Directed self-checking bench for mult_ctrl with a pipelined
//            multiplier model. Define MULT_CTRL_MADD_EN to exercise MADD.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_ctrl;
  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 5;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MFHI  = 3'd3;
  localparam logic [2:0] OP_MFLO  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_7     = 3'd7;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              op_valid = 1'b0;
  logic              flush = 1'b0;
  logic [2:0]        op = OP_NOP;
  logic [WIDTH-1:0]  rs_val = '0;
  logic [WIDTH-1:0]  rt_val = '0;
  logic              op_ready;
  logic              rd_valid;
  logic [WIDTH-1:0]  rd_data;
  logic [WIDTH-1:0]  mul_a;
  logic [WIDTH-1:0]  mul_b;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;
  logic [2*WIDTH-1:0] mul_p;
  logic [2*WIDTH-1:0] pipe [MUL_LAT-1];

  int checks = 0;
  int errors = 0;

  mult_ctrl #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .flush(flush), .op_ready(op_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Multiplier model: product becomes visible just before the commit edge.
  always @(posedge clk) begin
    pipe[0] <= {32'b0, mul_a} * {32'b0, mul_b};
    for (int i = 1; i < MUL_LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_p = pipe[MUL_LAT-2];

  // Presents one op for exactly one edge; returns on the negedge after acceptance.
  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    op_valid = 1'b0; op = OP_NOP;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready got %b exp 1", op_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h exp 0", {hi, lo}); end
    checks++; if ({mul_a, mul_b} !== 64'h0) begin errors++; $display("FAIL reset_mul_ab got %h exp 0", {mul_a, mul_b}); end
    rst = 1'b0;
  endtask

  task automatic test_mult_latency();
    int low = 1;
    drive(OP_MULT, 32'd3, 32'hFFFF_FFFC);
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL lat_busy got %b exp 0", op_ready); end
    checks++; if ({mul_a, mul_b} !== {32'd3, 32'd4}) begin errors++; $display("FAIL lat_mag got %h exp %h", {mul_a, mul_b}, {32'd3, 32'd4}); end
    for (int k = 0; k < MUL_LAT - 1; k++) begin
      @(negedge clk); #1;
      if (op_ready === 1'b0) low++;
    end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL lat_early got lo=%h exp 0", lo); end
    @(negedge clk); #1;
    checks++; if (low !== MUL_LAT) begin errors++; $display("FAIL lat_busy_cycles got %0d exp %0d", low, MUL_LAT); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL lat_ready got %b exp 1", op_ready); end
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF4) begin errors++; $display("FAIL lat_result got %h exp FFFFFFFFFFFFFFF4", {hi, lo}); end
  endtask

  task automatic test_mult_vectors();
    logic [2:0]  vop [4] = '{OP_MULTU, OP_MULT, OP_MULT, OP_MULT};
    logic [31:0] va  [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0};
    logic [31:0] vb  [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF};
    logic [63:0] vp  [4] = '{64'hFFFF_FFFE_0000_0001, 64'h4000_0000_0000_0000,
                             64'hFFFF_FFFF_8000_0000, 64'h0};
    logic [63:0] vab [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_8000_0000,
                             64'h8000_0000_0000_0001, 64'h0000_0000_0000_0001};
    for (int i = 0; i < 4; i++) begin
      drive(vop[i], va[i], vb[i]);
      repeat (MUL_LAT) @(negedge clk);
      #1;
      checks++; if ({hi, lo} !== vp[i]) begin errors++; $display("FAIL vec%0d_hilo got %h exp %h", i, {hi, lo}, vp[i]); end
      checks++; if ({mul_a, mul_b} !== vab[i]) begin errors++; $display("FAIL vec%0d_mag got %h exp %h", i, {mul_a, mul_b}, vab[i]); end
    end
  endtask

  task automatic test_move();
    drive(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
    checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi got %h exp DEADBEEF", hi); end
    drive(OP_MTLO, 32'h1234_5678, 32'h0);
    checks++; if (lo !== 32'h1234_5678) begin errors++; $display("FAIL mtlo got %h exp 12345678", lo); end
    @(negedge clk);
    op_valid = 1'b1; op = OP_MFHI; #1;
    checks++; if ({rd_valid, rd_data} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL mfhi got %b/%h exp 1/DEADBEEF", rd_valid, rd_data); end
    op = OP_MFLO; #1;
    checks++; if ({rd_valid, rd_data} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL mflo got %b/%h exp 1/12345678", rd_valid, rd_data); end
    op_valid = 1'b0; #1;
    checks++; if ({rd_valid, rd_data} !== {1'b0, 32'h0}) begin errors++; $display("FAIL mf_idle got %b/%h exp 0/0", rd_valid, rd_data); end
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    @(negedge clk);
    op_valid = 1'b1; op = OP_MULT; rs_val = 32'd7; rt_val = 32'd6;
    @(negedge clk);
    op = OP_MFHI; #1;
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL b2b_held got %b exp 0", op_ready); end
    if (rd_valid !== 1'b0) seen++;
    for (int k = 0; k < MUL_LAT - 1; k++) begin
      @(negedge clk); #1;
      if (rd_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL b2b_rd_while_busy got %0d exp 0", seen); end
    @(negedge clk); #1;
    checks++; if ({op_ready, rd_valid, rd_data} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL b2b_mfhi got %b/%b/%h exp 1/1/0", op_ready, rd_valid, rd_data); end
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL b2b_lo got %h exp 2a", lo); end
    @(negedge clk);
    op_valid = 1'b0; op = OP_NOP;
  endtask

  task automatic test_flush();
    drive(OP_MTLO, 32'h1234, 32'h0);
    drive(OP_MULT, 32'd2, 32'd2);
    repeat (3) @(negedge clk);
    flush = 1'b1; #1;
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_low got %b exp 0", op_ready); end
    @(negedge clk);
    flush = 1'b0; #1;
    checks++; if ({op_ready, lo} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL flush_mid got %b/%h exp 1/1234", op_ready, lo); end
    repeat (MUL_LAT) @(negedge clk);
    #1;
    checks++; if (lo !== 32'h1234) begin errors++; $display("FAIL flush_no_late got %h exp 1234", lo); end
    drive(OP_MULT, 32'd2, 32'd3);
    repeat (MUL_LAT - 1) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; #1;
    checks++; if ({op_ready, lo} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL flush_vs_done got %b/%h exp 1/1234", op_ready, lo); end
    @(negedge clk);
    flush = 1'b1; op_valid = 1'b1; op = OP_MTLO; rs_val = 32'h5555; #1;
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL flush_vs_op_ready got %b exp 0", op_ready); end
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0; op = OP_NOP; #1;
    checks++; if (lo !== 32'h1234) begin errors++; $display("FAIL flush_vs_op got %h exp 1234", lo); end
  endtask

  task automatic test_async_reset();
    drive(OP_MULT, 32'd5, 32'd5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({op_ready, hi, lo} !== {1'b1, 64'h0}) begin errors++; $display("FAIL areset got %b/%h/%h exp 1/0/0", op_ready, hi, lo); end
    @(negedge clk);
    rst = 1'b0;
    repeat (MUL_LAT + 1) @(negedge clk);
    #1;
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL areset_discard got %h exp 0", lo); end
  endtask

`ifdef MULT_CTRL_MADD_EN
  task automatic test_madd();
    drive(OP_MTHI, 32'h0, 32'h0);
    drive(OP_MTLO, 32'd10, 32'h0);
    drive(OP_7, 32'hFFFF_FFFF, 32'd3);
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL madd_busy got %b exp 0", op_ready); end
    repeat (MUL_LAT) @(negedge clk);
    #1;
    checks++; if ({hi, lo} !== 64'd7) begin errors++; $display("FAIL madd_result got %h exp 7", {hi, lo}); end
    drive(OP_MULT, 32'd2, 32'd3);
    repeat (MUL_LAT) @(negedge clk);
    #1;
    checks++; if ({hi, lo} !== 64'd6) begin errors++; $display("FAIL madd_acc_clear got %h exp 6", {hi, lo}); end
  endtask
`else
  task automatic test_op7_nop();
    drive(OP_MTLO, 32'hAAAA, 32'h0);
    @(negedge clk);
    op_valid = 1'b1; op = OP_7; rs_val = 32'd2; rt_val = 32'd3; #1;
    checks++; if ({op_ready, rd_valid} !== 2'b10) begin errors++; $display("FAIL op7_accept got %b%b exp 10", op_ready, rd_valid); end
    @(negedge clk);
    op_valid = 1'b0; op = OP_NOP; #1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL op7_no_run got %b exp 1", op_ready); end
    repeat (MUL_LAT + 1) @(negedge clk);
    #1;
    checks++; if ({hi, lo} !== {32'h0, 32'hAAAA}) begin errors++; $display("FAIL op7_hilo got %h exp aaaa", {hi, lo}); end
  endtask
`endif

  initial begin
    test_reset();
    test_mult_latency();
    test_mult_vectors();
    test_move();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef MULT_CTRL_MADD_EN
    test_madd();
`else
    test_op7_nop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
